// File: rtl/deser_pkg.sv
// Shared types and constants for the 7:1 OVIDEO receive deserializer.
package deser_pkg;

  localparam int WORD_W = 7;
  localparam int PH_W   = $clog2(WORD_W);

  // 4:3 pixel-clock pattern, bit 0 first on the wire
  localparam logic [WORD_W-1:0] DEF_TRAIN_PAT = 7'b110_0011;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } state_t;

endpackage

// File: rtl/video_deser7_if.sv
// Serial-in / word-out bundle of the deserializer; slave is the deserializer side.
interface video_deser7_if;
  import deser_pkg::*;

  logic              sdata;
  logic              train;
  logic [WORD_W-1:0] word_dat;
  logic              word_vld;
  logic              locked;
  logic              slip;

  modport master (
    output sdata, train,
    input  word_dat, word_vld, locked, slip
  );

  modport slave (
    input  sdata, train,
    output word_dat, word_vld, locked, slip
  );

endinterface

// File: rtl/deser7_shift.sv
// Serial shifter and word-phase counter; word/stb are combinational on the ph==6 cycle.
// No backpressure: shifts every cycle, hold only stretches phase 0 by one cycle.
module deser7_shift
  import deser_pkg::*;
(
  input  logic              clk_i,
  input  logic              nrst_i,
  input  logic              sdata,
  input  logic              hold,
  output logic [WORD_W-1:0] word,
  output logic              stb
);

  localparam logic [PH_W-1:0] PH_LAST = PH_W'(WORD_W - 1);

  // Only the six most recent bits are needed; the seventh is the live input.
  logic [WORD_W-1:1] sr;
  logic [PH_W-1:0]   ph;

  assign word = {sdata, sr};
  assign stb  = (ph == PH_LAST);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      sr <= '0;
      ph <= '0;
    end else begin
      sr <= word[WORD_W-1:1];
      if (!hold) begin
        ph <= stb ? '0 : ph + PH_W'(1);
      end
    end
  end

endmodule

// File: rtl/video_deser7.sv
// 1:7 deserializer with training-pattern word alignment (HUNT/VERIFY/LOCKED).
// Word, valid, lock and slip are registered on the strobe edge; no backpressure.
module video_deser7
  import deser_pkg::*;
#(
  parameter logic [WORD_W-1:0] TRAIN_PAT = DEF_TRAIN_PAT,
  parameter int                LOCK_CNT  = 4,
  parameter int                LOSS_CNT  = 4
) (
  input  logic          clk_i,
  input  logic          nrst_i,
  video_deser7_if.slave bus
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(LOSS_CNT + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CNT - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(LOSS_CNT - 1);

  logic [WORD_W-1:0] wrd;
  logic              stb;
  logic              hit;

  state_t            state;
  logic [LW-1:0]     mcnt;
  logic [MW-1:0]     miss;
  logic [WORD_W-1:0] word_q;
  logic              valid_q;
  logic              locked_q;
  logic              slip_q;

  // The registered slip pulse is the phase hold, so the boundary moves one bit later.
  deser7_shift u_shift (
    .clk_i  (clk_i),
    .nrst_i (nrst_i),
    .sdata  (bus.sdata),
    .hold   (slip_q),
    .word   (wrd),
    .stb    (stb)
  );

  assign hit = (wrd == TRAIN_PAT);

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state    <= HUNT;
      mcnt     <= '0;
      miss     <= '0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      locked_q <= 1'b0;
      slip_q   <= 1'b0;
    end else begin
      valid_q <= stb;
      slip_q  <= 1'b0;
      if (stb) begin
        word_q <= wrd;
        case (state)
          HUNT: begin
            if (hit) begin
              if (LOCK_CNT == 1) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end else begin
                state <= VERIFY;
                mcnt  <= LW'(1);
              end
            end else begin
              slip_q <= 1'b1;
            end
          end
          VERIFY: begin
            if (hit) begin
              if (mcnt >= LOCK_LAST) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
                mcnt     <= '0;
              end else begin
                mcnt <= mcnt + LW'(1);
              end
            end else begin
              state  <= HUNT;
              mcnt   <= '0;
              slip_q <= 1'b1;
            end
          end
          LOCKED: begin
            // Misses only count while the far end claims to be training.
            if (bus.train && !hit) begin
              if (miss >= MISS_LAST) begin
                state    <= HUNT;
                locked_q <= 1'b0;
                miss     <= '0;
              end else begin
                miss <= miss + MW'(1);
              end
            end else begin
              miss <= '0;
            end
          end
          default: begin
            state    <= HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.word_dat = word_q;
  assign bus.word_vld = valid_q;
  assign bus.locked   = locked_q;
  assign bus.slip     = slip_q;

endmodule
